tx_scheduler: RTL and testbench

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_tx_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// ---------------------------------------------------------------------------
// tx_scheduler
//
// Picks which transmit mailbox goes onto the bus next and walks it through
// bus arbitration and frame transmission. Among the mailboxes that are
// requesting and not yet served, the one with the numerically lowest 11-bit
// ID wins. Ties go to the lowest mailbox index. A lost arbitration sends the
// FSM back to IDLE, so any higher-priority request that arrived meanwhile is
// chosen on the next selection pass.
//
// Optional feature (macro TX_RETRY_LIMIT_EN):
//   When this macro is defined, each mailbox keeps a 4-bit count of lost
//   arbitrations. When a loss brings that count to RETRY_MAX, the message is
//   failed: tx_fail pulses and the mailbox is masked like a sent one. When the
//   macro is undefined, losses are retried forever and tx_fail is always 0.
//
// Parameters:
//   NUM_MB     number of mailboxes (2..8)
//   RETRY_MAX  lost arbitrations allowed per message (1..15)
//   ARB_CYCLES cycles in ARB with no result before the attempt counts as won
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   tx_req     per-mailbox level request, held until ack or fail
//   mb_id      packed IDs, mailbox k at [11k+10:11k]
//   bus_idle   bus idle, arbitration may start
//   arb_win    arbitration won
//   arb_lose   arbitration lost (takes priority over arb_win)
//   tx_done    one-cycle pulse, frame transmission complete
//   arb_start  high throughout ARB
//   arb_id     ID of the selected mailbox
//   tx_start   one-cycle pulse on the ARB->TX transition
//   tx_sel     selected mailbox index
//   tx_ack     one-hot pulse, mailbox sent
//   tx_fail    one-hot pulse, retries exhausted
//   busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module tx_scheduler #(
    parameter int NUM_MB     = 4,
    parameter int RETRY_MAX  = 8,
    parameter int ARB_CYCLES = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MB-1:0]         tx_req,
    input  logic [NUM_MB*11-1:0]      mb_id,
    input  logic                      bus_idle,
    input  logic                      arb_win,
    input  logic                      arb_lose,
    input  logic                      tx_done,
    output logic                      arb_start,
    output logic [10:0]               arb_id,
    output logic                      tx_start,
    output logic [$clog2(NUM_MB)-1:0] tx_sel,
    output logic [NUM_MB-1:0]         tx_ack,
    output logic [NUM_MB-1:0]         tx_fail,
    output logic                      busy
);

    localparam int ID_W  = 11;
    localparam int SEL_W = $clog2(NUM_MB);
    localparam int CNT_W = (ARB_CYCLES > 1) ? $clog2(ARB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ARB_CYCLES - 1);
    localparam logic [NUM_MB-1:0] MB_ONE   = NUM_MB'(1);

    // Reject out-of-range configurations at elaboration.
    if (NUM_MB < 2 || NUM_MB > 8 || RETRY_MAX < 1 || RETRY_MAX > 15 ||
        ARB_CYCLES < 1) begin : g_bad_params
        $error("tx_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT_IDLE,
        S_ARB,
        S_TX
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MB-1:0]  done_mask_q, done_mask_d;

    logic [NUM_MB-1:0]  eligible;
    logic               found;
    logic [SEL_W-1:0]   best_idx;
    logic [ID_W-1:0]    best_id;
    logic               lose_ev;
    logic               win_ev;
    logic               done_ev;
    logic               fail_ev;
    logic [NUM_MB-1:0]  sel_onehot;

    assign eligible   = tx_req & ~done_mask_q;
    assign sel_onehot = MB_ONE << sel_q;

    // Events consumed only in the state that owns them; arb_lose wins over
    // arb_win, and the ARB timeout counts as a win.
    assign lose_ev = (state_q == S_ARB) && arb_lose;
    assign win_ev  = (state_q == S_ARB) && !arb_lose &&
                     (arb_win || (cnt_q == CNT_LAST));
    assign done_ev = (state_q == S_TX) && tx_done;

    // Lowest-ID search. Strict '<' keeps the lower index on equal IDs.
    // NOTE: combinational blocks use blocking '=' and give every variable
    // they write a default first, so the result is pure logic and no latch
    // can be inferred; registers are written only in always_ff with '<='.
    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_id  = '0;
        for (int k = 0; k < NUM_MB; k++) begin
            if (eligible[k] && (!found || (mb_id[k*ID_W +: ID_W] < best_id))) begin
                found    = 1'b1;
                best_idx = SEL_W'(k);
                best_id  = mb_id[k*ID_W +: ID_W];
            end
        end
    end

`ifdef TX_RETRY_LIMIT_EN
    logic [NUM_MB-1:0][3:0] retry_q, retry_d;
    logic [3:0]             retry_inc;

    assign retry_inc = retry_q[sel_q] + 4'd1;
    assign fail_ev   = lose_ev && (retry_inc == 4'(RETRY_MAX));

    always_comb begin
        retry_d = retry_q;
        if (done_ev) begin
            retry_d[sel_q] = 4'd0;
        end else if (lose_ev) begin
            retry_d[sel_q] = fail_ev ? 4'd0 : retry_inc;
        end
    end
`else
    assign fail_ev = 1'b0;
`endif

    // ---------------- state register + datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            done_mask_q <= '0;
`ifdef TX_RETRY_LIMIT_EN
            // NOTE: the per-mailbox counter array is reset explicitly; a stale
            // count left over from before reset would shorten a later
            // message's retry budget.
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            done_mask_q <= done_mask_d;
`ifdef TX_RETRY_LIMIT_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (|eligible) state_d = S_SELECT;
            S_SELECT:    state_d = found ? S_WAIT_IDLE : S_IDLE;
            S_WAIT_IDLE: begin
                // A request withdrawn before arbitration is dropped silently.
                if (!tx_req[sel_q]) begin
                    state_d = S_IDLE;
                end else if (bus_idle) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (lose_ev) begin
                    state_d = S_IDLE;
                end else if (win_ev) begin
                    state_d = S_TX;
                end
            end
            S_TX:        if (done_ev) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        sel_d = sel_q;
        id_d  = id_q;
        if (state_q == S_SELECT && found) begin
            sel_d = best_idx;
            id_d  = best_id;
        end
        // The ARB cycle counter restarts from 0 on every entry into ARB.
        cnt_d = ((state_q == S_ARB) && (state_d == S_ARB)) ? cnt_q + 1'b1 : '0;
        // A withdrawn request always clears its mask bit, even in the cycle the
        // bit would be set, so a later request from that mailbox is served again.
        done_mask_d = (done_mask_q | ((done_ev || fail_ev) ? sel_onehot : '0)) & tx_req;
    end

    // ---------------- outputs ----------------
    // Pulses are gated with rst so that a reset landing in ARB or TX aborts the
    // message without a stray start, ack or fail.
    always_comb begin
        busy      = (state_q != S_IDLE);
        arb_start = (state_q == S_ARB);
        tx_start  = win_ev && !rst;
        tx_ack    = (done_ev && !rst) ? sel_onehot : '0;
        tx_fail   = (fail_ev && !rst) ? sel_onehot : '0;
    end

    assign tx_sel = sel_q;
    assign arb_id = id_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_scheduler
//
// Self-checking bench for tx_scheduler (NUM_MB=4, RETRY_MAX=8, ARB_CYCLES=11).
// A table of selection vectors checks the lowest-ID / lowest-index choice;
// hand-written sequences cover ack timing, reselection after a lost
// arbitration, the ARB timeout, reset during TX, withdrawal in WAIT_IDLE,
// done-mask clearing and the retry limit (TX_RETRY_LIMIT_EN).
// ---------------------------------------------------------------------------
module tb_tx_scheduler;

    localparam int NUM_MB = 4;

`ifdef TX_RETRY_LIMIT_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_MB-1:0] tx_req;
    logic [NUM_MB*11-1:0] mb_id;
    logic              bus_idle;
    logic              arb_win;
    logic              arb_lose;
    logic              tx_done;
    logic              arb_start;
    logic [10:0]       arb_id;
    logic              tx_start;
    logic [1:0]        tx_sel;
    logic [NUM_MB-1:0] tx_ack;
    logic [NUM_MB-1:0] tx_fail;
    logic              busy;

    tx_scheduler #(
        .NUM_MB     (NUM_MB),
        .RETRY_MAX  (8),
        .ARB_CYCLES (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_req    (tx_req),
        .mb_id     (mb_id),
        .bus_idle  (bus_idle),
        .arb_win   (arb_win),
        .arb_lose  (arb_lose),
        .tx_done   (tx_done),
        .arb_start (arb_start),
        .arb_id    (arb_id),
        .tx_start  (tx_start),
        .tx_sel    (tx_sel),
        .tx_ack    (tx_ack),
        .tx_fail   (tx_fail),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tx_req   = '0;
        bus_idle = 1'b0;
        arb_win  = 1'b0;
        arb_lose = 1'b0;
        tx_done  = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    // Step until arb_start rises, at most max_cycles; returns cycles taken.
    task automatic wait_arb(input int max_cycles, output int cycles);
        cycles = 0;
        while (!arb_start && cycles < max_cycles) begin
            step();
            cycles++;
        end
    endtask

    function automatic logic [43:0] ids4(input logic [10:0] i0, input logic [10:0] i1,
                                         input logic [10:0] i2, input logic [10:0] i3);
        return {i3, i2, i1, i0};
    endfunction

    typedef struct {
        logic [3:0]  req;
        logic [43:0] ids;
        logic [1:0]  exp_sel;
        logic [10:0] exp_id;
    } sel_vec_t;

    sel_vec_t vecs[6];

    // Watchdog: never let the run hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          starts;
        logic [3:0]  acks;
        logic [3:0]  fails;
        logic [3:0]  exp_fail;

        // selection vectors: {req, ids (mb0..mb3), expected tx_sel, expected arb_id}
        vecs[0] = '{4'b0001, ids4(11'h555, 11'h001, 11'h001, 11'h001), 2'd0, 11'h555};
        vecs[1] = '{4'b1000, ids4(11'h001, 11'h002, 11'h003, 11'h7FF), 2'd3, 11'h7FF};
        vecs[2] = '{4'b1111, ids4(11'h050, 11'h100, 11'h200, 11'h005), 2'd3, 11'h005};
        vecs[3] = '{4'b0110, ids4(11'h000, 11'h0AA, 11'h0AA, 11'h000), 2'd1, 11'h0AA};
        vecs[4] = '{4'b1010, ids4(11'h000, 11'h7FF, 11'h000, 11'h000), 2'd3, 11'h000};
        vecs[5] = '{4'b0101, ids4(11'h400, 11'h001, 11'h3FF, 11'h001), 2'd2, 11'h3FF};

        mb_id = '0;

        // ---------------- reset state ----------------
        do_reset();
        check("reset busy", busy, 0);
        check("reset arb_start", arb_start, 0);
        check("reset tx_start", tx_start, 0);
        check("reset tx_ack", tx_ack, 0);
        check("reset tx_fail", tx_fail, 0);
        check("reset arb_id", arb_id, 0);
        check("reset tx_sel", tx_sel, 0);

        // ---------------- table: selection ----------------
        for (int i = 0; i < 6; i++) begin
            do_reset();
            mb_id  = vecs[i].ids;
            tx_req = vecs[i].req;
            step();   // SELECT
            step();   // WAIT_IDLE (bus_idle=0 keeps it there)
            check($sformatf("vec%0d tx_sel", i), tx_sel, vecs[i].exp_sel);
            check($sformatf("vec%0d arb_id", i), arb_id, vecs[i].exp_id);
            check($sformatf("vec%0d busy", i), busy, 1);
            check($sformatf("vec%0d arb_start", i), arb_start, 0);
            tx_req = '0;
            step();
            check($sformatf("vec%0d idle after withdraw", i), busy, 0);
        end

        // ---------------- A: select mb2, win, ack after 20 cycles ----------------
        do_reset();
        mb_id    = ids4(11'h7FF, 11'h123, 11'h0A0, 11'h7FF);
        tx_req   = 4'b0110;
        bus_idle = 1'b1;
        #1;
        check("A busy before select", busy, 0);
        wait_arb(10, n);
        check("A arb_start", arb_start, 1);
        check("A arb_start latency", n, 3);
        check("A arb_id", arb_id, 11'h0A0);
        check("A tx_sel", tx_sel, 2);
        arb_win = 1'b1;
        #1;
        check("A tx_start on win", tx_start, 1);
        starts = 1;
        acks   = '0;
        step();
        arb_win = 1'b0;
        #1;
        check("A arb_start low in TX", arb_start, 0);
        check("A busy in TX", busy, 1);
        for (int c = 0; c < 19; c++) begin
            starts += int'(tx_start);
            acks   |= tx_ack;
            step();
        end
        starts += int'(tx_start);
        acks   |= tx_ack;
        check("A single tx_start", starts, 1);
        check("A no early ack", acks, 0);
        tx_done = 1'b1;
        #1;
        check("A tx_ack", tx_ack, 4'b0100);
        check("A tx_fail with ack", tx_fail, 0);
        step();
        tx_done = 1'b0;
        #1;
        check("A busy falls", busy, 0);
        check("A ack one cycle", tx_ack, 0);
        step();
        step();
        check("A next tx_sel (mb2 masked)", tx_sel, 1);
        check("A next arb_id", arb_id, 11'h123);

        // ---------------- B: lose, higher-priority mb0 arrives ----------------
        step();
        check("B in ARB", arb_start, 1);
        arb_lose = 1'b1;
        arb_win  = 1'b1;
        tx_req   = 4'b0111;
        mb_id    = ids4(11'h010, 11'h123, 11'h0A0, 11'h7FF);
        #1;
        check("B lose beats win", tx_start, 0);
        step();
        arb_lose = 1'b0;
        arb_win  = 1'b0;
        #1;
        check("B idle after lose", busy, 0);
        check("B no ack on lose", tx_ack, 0);
        step();
        step();
        check("B reselect arb_id", arb_id, 11'h010);
        check("B reselect tx_sel", tx_sel, 0);

        // ---------------- C: ARB timeout ----------------
        step();
        check("C in ARB", arb_start, 1);
        n = 1;
        while (!tx_start && n < 20) begin
            step();
            n++;
        end
        check("C tx_start on timeout", tx_start, 1);
        check("C timeout ARB cycle", n, 11);
        step();
        tx_done = 1'b1;
        #1;
        check("C tx_ack", tx_ack, 4'b0001);
        step();
        tx_done = 1'b0;
        tx_req  = '0;

        // ---------------- D: reset during TX ----------------
        do_reset();
        mb_id    = ids4(11'h7FF, 11'h123, 11'h0A0, 11'h7FF);
        tx_req   = 4'b0100;
        bus_idle = 1'b1;
        wait_arb(10, n);
        check("D reach ARB", arb_start, 1);
        arb_win = 1'b1;
        step();
        arb_win = 1'b0;
        rst     = 1'b1;
        tx_done = 1'b1;
        #1;
        check("D no ack while rst", tx_ack, 0);
        step();
        rst = 1'b0;
        #1;
        check("D no ack after rst", tx_ack, 0);
        check("D busy", busy, 0);
        check("D arb_start", arb_start, 0);
        check("D tx_start", tx_start, 0);
        check("D tx_fail", tx_fail, 0);
        check("D arb_id cleared", arb_id, 0);
        check("D tx_sel cleared", tx_sel, 0);
        tx_done = 1'b0;
        tx_req  = '0;
        step();

        // ---------------- E: withdraw in WAIT_IDLE ----------------
        do_reset();
        tx_req = 4'b0001;
        step();
        step();
        step();
        check("E waiting for bus", busy, 1);
        check("E no arb while bus busy", arb_start, 0);
        tx_req   = '0;
        bus_idle = 1'b1;
        acks     = '0;
        fails    = '0;
        step();
        check("E idle after withdraw", busy, 0);
        for (int c = 0; c < 3; c++) begin
            acks  |= tx_ack;
            fails |= tx_fail;
            step();
        end
        check("E no ack", acks, 0);
        check("E no fail", fails, 0);

        // ---------------- F: done_mask holds then clears ----------------
        do_reset();
        mb_id    = ids4(11'h7FF, 11'h123, 11'h0A0, 11'h7FF);
        tx_req   = 4'b0100;
        bus_idle = 1'b1;
        wait_arb(10, n);
        arb_win = 1'b1;
        step();
        arb_win = 1'b0;
        tx_done = 1'b1;
        #1;
        check("F ack", tx_ack, 4'b0100);
        step();
        tx_done = 1'b0;
        step();
        step();
        check("F held request not reselected", busy, 0);
        tx_req = '0;
        step();
        tx_req = 4'b0100;
        step();
        check("F re-request served", busy, 1);
        tx_req = '0;
        step();
        step();

        // ---------------- G: repeated loss on mb1 ----------------
        do_reset();
        mb_id    = ids4(11'h7FF, 11'h123, 11'h0A0, 11'h7FF);
        tx_req   = 4'b0010;
        bus_idle = 1'b1;
        acks     = '0;
        for (int a = 1; a <= 8; a++) begin
            wait_arb(10, n);
            check($sformatf("G attempt %0d reaches ARB", a), arb_start, 1);
            arb_lose = 1'b1;
            #1;
            exp_fail = (RETRY_EN && a == 8) ? 4'b0010 : 4'b0000;
            check($sformatf("G attempt %0d tx_fail", a), tx_fail, exp_fail);
            acks |= tx_ack;
            step();
            arb_lose = 1'b0;
            #1;
        end
        check("G no ack", acks, 0);
        step();
        check("G busy after last loss", busy, RETRY_EN ? 0 : 1);
        tx_req = '0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
